alu_display_mux: RTL and testbench
==================================

ALU_DISPLAY_MUX -- requirements
Module: alu_display_mux

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, clock cycles each digit is driven; legal range >= 2.
REQ-002 The block SHALL have parameter BLINK_DIV, default 250, digit periods per error-blink phase; legal range >= 1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port load  input  1  capture strobe for ALU result.
REQ-006 The block SHALL have port dec_bin  input  4  ALU tens digit.
REQ-007 The block SHALL have port unis_bin  input  4  ALU units digit.
REQ-008 The block SHALL have port zero  input  1  ALU zero flag.
REQ-009 The block SHALL have port error  input  1  ALU error flag.
REQ-010 The block SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 The block SHALL have port an  output  2  digit enables, active-low, registered; an[0] = units, an[1] = tens.
REQ-012 The block SHALL have port zero_led  output  1  latched zero flag, registered.
REQ-013 The block SHALL have port err_led  output  1  latched error flag, registered.

Function
REQ-014 When load=1 at a rising edge, the block SHALL latch dec_bin, unis_bin, zero and error at that edge; when load=0, latched values SHALL hold.
REQ-015 zero_led and err_led SHALL equal the latched zero and error values from the edge after capture onward.
REQ-016 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, scan state SHALL toggle between UNITS and TENS.
REQ-017 In scan state UNITS, an SHALL be 2'b10; in scan state TENS, an SHALL be 2'b01; only one digit SHALL ever be enabled.
REQ-018 seg and an SHALL be registered: they SHALL reflect scan state and latched data one clock after either changes.
REQ-019 Digit encoding SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, dash=0111111, blank=1111111.
REQ-020 With latched error=0, units digit SHALL show latched unis value; values 10..15 SHALL show dash.
REQ-021 With latched error=0, tens digit SHALL show blank when latched dec=0 (leading-zero blanking), dash for 10..15, otherwise its digit.
REQ-022 With latched error=1, both digits SHALL show E regardless of digit values.
REQ-023 A blink counter SHALL advance once per scan-state toggle, wrap at BLINK_DIV-1, and toggle a blink phase on wrap.
REQ-024 During the blink-off phase with latched error=1, seg SHALL be blank; an SHALL keep scanning.
REQ-025 Blink counter and blink phase SHALL run only while latched error=1; when latched error=0 they SHALL be held at 0 / ON.
REQ-026 Capturing a new value SHALL NOT reset the refresh counter or scan state; the display SHALL change at most one clock after capture.
REQ-027 load held high continuously SHALL recapture every cycle, with no other side effect.

Reset
REQ-028 When rst_n=0 at a rising edge, all latches, both counters and zero_led/err_led SHALL clear to 0, scan state SHALL go to UNITS, blink phase SHALL go to ON, an SHALL go to 2'b11, and seg SHALL go to blank.
REQ-029 Reset SHALL override load in the same cycle; scanning SHALL resume from UNITS with counter 0 on the first edge with rst_n=1.
REQ-030 After reset with no load, the display SHALL show units 0 and a blank tens digit.

Verification (REFRESH_DIV=4, BLINK_DIV=2)
REQ-031 Reset, no load -> an alternates 10/01 every 4 clocks; seg = 1000000 on units and 1111111 on tens.
REQ-032 load with dec=4, unis=2, zero=0, error=0 -> tens seg 0011001, units seg 0100100; err_led=0; zero_led=0.
REQ-033 load with dec=0, unis=0, zero=1 -> zero_led=1; tens blank; units 1000000.
REQ-034 load with dec=15, unis=15, error=1 -> both digits 0000110 for 2 digit periods, then blank for 2 periods, repeating; err_led=1.
REQ-035 load with dec=12, unis=11, error=0 -> both digits dash.
REQ-036 rst_n low for 1 cycle mid-scan (TENS, counter=2) while error is blinking -> next cycle an=11, seg blank, LEDs 0; then UNITS resumes showing 0.

Source files
------------

// File: rtl/alu_display_mux.sv
// alu_display_mux
// Captures a two-digit ALU result with its zero/error flags and drives a
// two-digit, time-multiplexed, active-low seven-segment display. The tens
// digit is blanked when zero, out-of-range digits show a dash, and an error
// result shows "EE", blinking at a rate set by BLINK_DIV.
module alu_display_mux #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] dec_bin,
   input  logic [3:0] unis_bin,
   input  logic       zero,
   input  logic       error,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       zero_led,
   output logic       err_led
);

   // Counter widths. A divider of 1 still needs a 1-bit counter.
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_DIV - 1);

   // Segment patterns, bit order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] GLYPH_E     = 7'b0000110;
   localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   // Which digit the scanner is currently driving.
   typedef enum logic {
      SCAN_UNITS = 1'b0,
      SCAN_TENS  = 1'b1
   } scan_t;

   // Latched ALU result.
   logic [3:0]    dec_reg;
   logic [3:0]    unis_reg;
   logic          zero_reg;
   logic          err_reg;

   // Scanner and blink state.
   logic [RW-1:0] refresh_cnt_reg;
   scan_t         scan_reg;
   logic [BW-1:0] blink_cnt_reg;
   logic          blink_off_reg;

   // Registered outputs.
   logic [6:0]    seg_reg;
   logic [1:0]    an_reg;
   logic          zero_led_reg;
   logic          err_led_reg;

   // Combinational next values for the display registers.
   logic [1:0][6:0] glyph_next;
   logic [6:0]      seg_next;
   logic [1:0]      an_next;
   logic            refresh_wrap;
   logic            blink_wrap;

   // Decimal digit to segment pattern; anything above 9 is shown as a dash.
   function automatic logic [6:0] digit_glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = GLYPH_DASH;
      endcase
      return g;
   endfunction

   assign refresh_wrap = (refresh_cnt_reg == REFRESH_MAX);
   assign blink_wrap   = (blink_cnt_reg == BLINK_MAX);

   // Per-digit glyph selection: index 0 is the units digit, 1 the tens digit.
   // Error overrides the digit values; only the tens digit gets leading-zero
   // blanking.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_digit
         logic [3:0] digit_val;
         logic       lead_blank;
         assign digit_val  = (gi == 0) ? unis_reg : dec_reg;
         assign lead_blank = (gi == 1) && (digit_val == 4'd0);
         assign glyph_next[gi] = err_reg    ? (blink_off_reg ? GLYPH_BLANK : GLYPH_E) :
                                 lead_blank ? GLYPH_BLANK :
                                              digit_glyph(digit_val);
      end
   endgenerate

   // Pick the pattern and the active-low enable for the digit being scanned.
   always_comb begin
      seg_next = glyph_next[scan_reg];
      an_next  = (scan_reg == SCAN_TENS) ? 2'b01 : 2'b10;
   end

   // Capture, refresh/blink counters and registered outputs. The outputs are
   // computed from the current scan state and latched data, so they follow
   // either one clock later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dec_reg         <= 4'd0;
         unis_reg        <= 4'd0;
         zero_reg        <= 1'b0;
         err_reg         <= 1'b0;
         refresh_cnt_reg <= '0;
         scan_reg        <= SCAN_UNITS;
         blink_cnt_reg   <= '0;
         blink_off_reg   <= 1'b0;
         seg_reg         <= GLYPH_BLANK;
         an_reg          <= 2'b11;
         zero_led_reg    <= 1'b0;
         err_led_reg     <= 1'b0;
      end else begin
         // A capture only touches the latches; scanning carries on untouched.
         if (load) begin
            dec_reg  <= dec_bin;
            unis_reg <= unis_bin;
            zero_reg <= zero;
            err_reg  <= error;
         end

         zero_led_reg <= zero_reg;
         err_led_reg  <= err_reg;

         if (refresh_wrap) begin
            refresh_cnt_reg <= '0;
            scan_reg        <= (scan_reg == SCAN_UNITS) ? SCAN_TENS : SCAN_UNITS;
         end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
         end

         // Blink timing runs only for an error result so that a new error
         // always starts with "EE" visible for a full blink phase.
         if (!err_reg) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
         end else if (refresh_wrap) begin
            if (blink_wrap) begin
               blink_cnt_reg <= '0;
               blink_off_reg <= ~blink_off_reg;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
         end

         seg_reg <= seg_next;
         an_reg  <= an_next;
      end
   end

   assign seg      = seg_reg;
   assign an       = an_reg;
   assign zero_led = zero_led_reg;
   assign err_led  = err_led_reg;

endmodule

// File: tb/tb_alu_display_mux.sv
// Directed testbench for alu_display_mux with REFRESH_DIV=4, BLINK_DIV=2.
module tb_alu_display_mux;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GE = 7'b0000110;
   localparam logic [6:0] GD = 7'b0111111;
   localparam logic [6:0] GB = 7'b1111111;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic [3:0] dec_bin;
   logic [3:0] unis_bin;
   logic       zero;
   logic       error;
   logic [6:0] seg;
   logic [1:0] an;
   logic       zero_led;
   logic       err_led;

   int n_cmp = 0;
   int n_bad = 0;

   alu_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .dec_bin  (dec_bin),
      .unis_bin (unis_bin),
      .zero     (zero),
      .error    (error),
      .seg      (seg),
      .an       (an),
      .zero_led (zero_led),
      .err_led  (err_led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Two reset edges, released so the next rising edge is the first scan edge.
   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Single-cycle load strobe, then one more edge so seg reflects the capture.
   task automatic do_load(input logic [3:0] d, input logic [3:0] u, input logic z, input logic e);
      dec_bin  = d;
      unis_bin = u;
      zero     = z;
      error    = e;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; load = 1'b1; dec_bin = 4'd4; unis_bin = 4'd2; zero = 1'b1; error = 1'b1;
      tick();
      tick();
      n_cmp++; if (an !== 2'b11) begin n_bad++; $display("FAIL reset_an actual=%b required=%b", an, 2'b11); end
      n_cmp++; if (seg !== GB) begin n_bad++; $display("FAIL reset_seg actual=%b required=%b", seg, GB); end
      n_cmp++; if (zero_led !== 1'b0) begin n_bad++; $display("FAIL reset_zero_led actual=%b required=0", zero_led); end
      n_cmp++; if (err_led !== 1'b0) begin n_bad++; $display("FAIL reset_err_led actual=%b required=0", err_led); end
      rst_n = 1'b1; load = 1'b0;
      tick();
      n_cmp++; if (an !== 2'b10) begin n_bad++; $display("FAIL reset_resume_an actual=%b required=%b", an, 2'b10); end
      n_cmp++; if (seg !== G0) begin n_bad++; $display("FAIL reset_resume_seg actual=%b required=%b", seg, G0); end
      tick();
      n_cmp++; if (zero_led !== 1'b0 || err_led !== 1'b0) begin
         n_bad++; $display("FAIL reset_load_ignored actual=%b%b required=00", zero_led, err_led);
      end
      $display("test_reset done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   task automatic test_idle_scan();
      logic [1:0] exp_an;
      logic [6:0] exp_seg;
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_an  = (((k - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10;
         exp_seg = (exp_an == 2'b01) ? GB : G0;
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL idle_an k=%0d actual=%b required=%b", k, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL idle_seg k=%0d actual=%b required=%b", k, seg, exp_seg); end
      end
      $display("test_idle_scan done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   task automatic test_digits();
      do_load(4'd4, 4'd2, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (an == 2'b10) begin
            if (seg !== G2) begin n_bad++; $display("FAIL digits_units actual=%b required=%b", seg, G2); end
         end else if (an == 2'b01) begin
            if (seg !== G4) begin n_bad++; $display("FAIL digits_tens actual=%b required=%b", seg, G4); end
         end else begin
            n_bad++; $display("FAIL digits_an actual=%b required=10 or 01", an);
         end
      end
      n_cmp++; if (zero_led !== 1'b0 || err_led !== 1'b0) begin
         n_bad++; $display("FAIL digits_leds actual=%b%b required=00", zero_led, err_led);
      end
      $display("test_digits done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   task automatic test_zero();
      do_load(4'd0, 4'd0, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (an == 2'b10) begin
            if (seg !== G0) begin n_bad++; $display("FAIL zero_units actual=%b required=%b", seg, G0); end
         end else if (an == 2'b01) begin
            if (seg !== GB) begin n_bad++; $display("FAIL zero_tens actual=%b required=%b", seg, GB); end
         end else begin
            n_bad++; $display("FAIL zero_an actual=%b required=10 or 01", an);
         end
      end
      n_cmp++; if (zero_led !== 1'b1) begin n_bad++; $display("FAIL zero_led actual=%b required=1", zero_led); end
      $display("test_zero done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   task automatic test_dash();
      do_load(4'd12, 4'd11, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (an != 2'b10 && an != 2'b01) begin
            n_bad++; $display("FAIL dash_an actual=%b required=10 or 01", an);
         end else if (seg !== GD) begin
            n_bad++; $display("FAIL dash_seg an=%b actual=%b required=%b", an, seg, GD);
         end
      end
      n_cmp++; if (zero_led !== 1'b0) begin n_bad++; $display("FAIL dash_zero_led actual=%b required=0", zero_led); end
      $display("test_dash done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   // Error captured on the first edge after reset: "EE" until the second scan
   // toggle, then alternating 8-clock blank / 8-clock "EE" phases.
   task automatic test_error_blink();
      logic [1:0] exp_an;
      logic [6:0] exp_seg;
      rst_n = 1'b0; load = 1'b0;
      tick();
      tick();
      rst_n = 1'b1; load = 1'b1; dec_bin = 4'd15; unis_bin = 4'd15; zero = 1'b0; error = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         load = 1'b0;
         exp_an = (((k - 1) / 4) % 2 == 1) ? 2'b01 : 2'b10;
         if (k == 1) exp_seg = G0;
         else exp_seg = (((k - 1) / 8) % 2 == 0) ? GE : GB;
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL blink_an k=%0d actual=%b required=%b", k, an, exp_an); end
         n_cmp++; if (seg !== exp_seg) begin n_bad++; $display("FAIL blink_seg k=%0d actual=%b required=%b", k, seg, exp_seg); end
         if (k >= 2) begin
            n_cmp++; if (err_led !== 1'b1) begin n_bad++; $display("FAIL blink_err_led k=%0d actual=%b required=1", k, err_led); end
         end
      end
      $display("test_error_blink done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   // Runs straight after test_error_blink: scanner is in TENS with counter 2
   // and the blink phase is off.
   task automatic test_reset_mid_scan();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (an !== 2'b11) begin n_bad++; $display("FAIL midrst_an actual=%b required=11", an); end
      n_cmp++; if (seg !== GB) begin n_bad++; $display("FAIL midrst_seg actual=%b required=%b", seg, GB); end
      n_cmp++; if (zero_led !== 1'b0 || err_led !== 1'b0) begin
         n_bad++; $display("FAIL midrst_leds actual=%b%b required=00", zero_led, err_led);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k <= 4) begin
            n_cmp++; if (an !== 2'b10 || seg !== G0) begin
               n_bad++; $display("FAIL midrst_units k=%0d actual an=%b seg=%b required an=10 seg=%b", k, an, seg, G0);
            end
         end else begin
            n_cmp++; if (an !== 2'b01 || seg !== GB) begin
               n_bad++; $display("FAIL midrst_tens actual an=%b seg=%b required an=01 seg=%b", an, seg, GB);
            end
         end
      end
      n_cmp++; if (err_led !== 1'b0) begin n_bad++; $display("FAIL midrst_err_led actual=%b required=0", err_led); end
      $display("test_reset_mid_scan done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   // load held high: LEDs track the inputs with two clocks of latency and the
   // scan sequence is exactly the same as with no loads.
   task automatic test_load_hold();
      logic [1:0] zv [8];
      logic [1:0] exp_an;
      do_reset();
      load = 1'b1; dec_bin = 4'd3; unis_bin = 4'd7;
      for (int i = 0; i < 8; i++) begin
         zv[i] = 2'(i);
         zero  = zv[i][0];
         error = zv[i][1];
         tick();
         exp_an = ((i / 4) % 2 == 1) ? 2'b01 : 2'b10;
         n_cmp++; if (an !== exp_an) begin n_bad++; $display("FAIL hold_an i=%0d actual=%b required=%b", i, an, exp_an); end
         if (i >= 1) begin
            n_cmp++; if ({err_led, zero_led} !== zv[i-1]) begin
               n_bad++; $display("FAIL hold_leds i=%0d actual=%b%b required=%b", i, err_led, zero_led, zv[i-1]);
            end
         end
      end
      load = 1'b0;
      $display("test_load_hold done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   // Two captures on consecutive edges: only the second one survives.
   task automatic test_back_to_back();
      do_reset();
      dec_bin = 4'd4; unis_bin = 4'd2; zero = 1'b1; error = 1'b1; load = 1'b1;
      tick();
      dec_bin = 4'd0; unis_bin = 4'd9; zero = 1'b0; error = 1'b0;
      tick();
      load = 1'b0;
      tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++;
         if (an == 2'b10) begin
            if (seg !== G9) begin n_bad++; $display("FAIL b2b_units actual=%b required=%b", seg, G9); end
         end else if (an == 2'b01) begin
            if (seg !== GB) begin n_bad++; $display("FAIL b2b_tens actual=%b required=%b", seg, GB); end
         end else begin
            n_bad++; $display("FAIL b2b_an actual=%b required=10 or 01", an);
         end
      end
      n_cmp++; if (zero_led !== 1'b0 || err_led !== 1'b0) begin
         n_bad++; $display("FAIL b2b_leds actual=%b%b required=00", zero_led, err_led);
      end
      $display("test_back_to_back done: %0d compared / %0d mismatched", n_cmp, n_bad);
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; dec_bin = 4'd0; unis_bin = 4'd0; zero = 1'b0; error = 1'b0;
      @(negedge clk);
      test_reset();
      test_idle_scan();
      test_digits();
      test_zero();
      test_dash();
      test_error_blink();
      test_reset_mid_scan();
      test_load_hold();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
